// File: rtl/reset_sequencer.sv
// Combines PLL lock, a debounced button and a software request into a qualified reset condition.
// It releases NUM_RESETS resets in order after a hold period, and counts lock losses in STAGE/RUN.
module reset_sequencer #(
  parameter int NUM_RESETS      = 2,
  parameter int HOLD_CYCLES     = 4194303,
  parameter int STAGE_DELAY     = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lock,
  input  logic                  button_n,
  input  logic                  sw_req,
  output logic [NUM_RESETS-1:0] reset_out,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [7:0]            lock_loss_count
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STAGE_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [HOLD_W-1:0]     HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAGE_W-1:0]    STAGE_LOAD = STAGE_W'(STAGE_DELAY - 1);
  localparam logic [DB_W-1:0]       DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_RESETS-1:0] ALL_ON     = '1;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   lock_s;
  logic                   btn_s;

  logic                   db_level_q, db_level_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STAGE_W-1:0]     stage_cnt_q, stage_cnt_d;
  logic [NUM_RESETS-1:0]  rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             llc_q, llc_d;

  logic                   pressed;
  logic                   qualified;
  logic                   abort;

  assign lock_s    = lock_sync_q[SYNC_STAGES-1];
  assign btn_s     = btn_sync_q[SYNC_STAGES-1];
  assign pressed   = ~db_level_q;
  assign qualified = lock_s & ~pressed;
  assign abort     = ~lock_s | pressed | sw_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], button_n};
    end
  end

  // Counter runs only while the synchronised level disagrees with the accepted one.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (btn_s != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stage_cnt_d = stage_cnt_q;
    rst_d       = rst_q;
    ready_d     = ready_q;
    llc_d       = llc_q;
    case (state_q)
      ST_HOLD: begin
        rst_d   = ALL_ON;
        ready_d = 1'b0;
        if (qualified && !sw_req) begin
          if (hold_cnt_q == '0) begin
            rst_d       = ALL_ON << 1;
            hold_cnt_d  = HOLD_LOAD;
            stage_cnt_d = STAGE_LOAD;
            if (rst_d == '0) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_STAGE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end else begin
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_STAGE, ST_RUN: begin
        // Abort is checked first so it beats a channel release on the same edge.
        if (abort) begin
          state_d    = ST_HOLD;
          rst_d      = ALL_ON;
          ready_d    = 1'b0;
          hold_cnt_d = HOLD_LOAD;
          if (!lock_s && llc_q != 8'hFF) begin
            llc_d = llc_q + 8'd1;
          end
        end else if (state_q == ST_STAGE) begin
          if (stage_cnt_q == '0) begin
            rst_d       = rst_q << 1;
            stage_cnt_d = STAGE_LOAD;
            if (rst_d == '0) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            stage_cnt_d = stage_cnt_q - STAGE_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_HOLD;
        rst_d      = ALL_ON;
        ready_d    = 1'b0;
        hold_cnt_d = HOLD_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_level_q  <= 1'b1;
      db_cnt_q    <= '0;
      state_q     <= ST_HOLD;
      hold_cnt_q  <= HOLD_LOAD;
      stage_cnt_q <= STAGE_LOAD;
      rst_q       <= ALL_ON;
      ready_q     <= 1'b0;
      llc_q       <= 8'd0;
    end else begin
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      llc_q       <= llc_d;
    end
  end

  assign reset_out       = rst_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, corner-case sequences and random stimulus,
// all checked against a timing-level reference model.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int H  = 16;
  localparam int S  = 4;
  localparam int SY = 2;
  localparam int D  = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         lock = 1'b1;
  logic         button_n = 1'b1;
  logic         sw_req = 1'b0;
  logic [N-1:0] reset_out;
  logic         ready;
  logic [1:0]   state;
  logic [7:0]   lock_loss_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .NUM_RESETS(N), .HOLD_CYCLES(H), .STAGE_DELAY(S),
    .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .lock(lock), .button_n(button_n), .sw_req(sw_req),
    .reset_out(reset_out), .ready(ready), .state(state), .lock_loss_count(lock_loss_count)
  );

  // Reference model: inputs seen through an SY-sample delay line, debounce as a run length
  // of disagreeing samples, sequencing as elapsed-time arithmetic since the first release.
  bit dl_lock[SY];
  bit dl_btn[SY];
  bit m_acc   = 1'b1;
  int m_diff  = 0;
  int m_phase = 0;  // 0 hold, 1 stage, 2 run
  int m_qual  = 0;
  int m_since = 0;
  int m_llc   = 0;

  function automatic logic [N-1:0] m_rst_out();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (m_phase == 0) ? 1'b1 : (m_since < k * S);
    return r;
  endfunction

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    bit ls, bs, qual, abrt;
    if (reset) begin
      for (int i = 0; i < SY; i++) begin dl_lock[i] = 0; dl_btn[i] = 0; end
      m_acc = 1; m_diff = 0; m_phase = 0; m_qual = 0; m_since = 0; m_llc = 0;
      return;
    end
    ls   = dl_lock[SY-1];
    bs   = dl_btn[SY-1];
    qual = ls && m_acc;
    abrt = !ls || !m_acc || sw_req;
    if (m_phase == 0) begin
      if (qual && !sw_req) begin
        m_qual++;
        if (m_qual == H) begin
          m_phase = (N == 1) ? 2 : 1;
          m_since = 0;
          m_qual  = 0;
        end
      end else begin
        m_qual = 0;
      end
    end else if (abrt) begin
      m_phase = 0;
      m_qual  = 0;
      if (!ls && m_llc < 255) m_llc++;
    end else if (m_phase == 1) begin
      m_since++;
      if (m_since >= (N - 1) * S) m_phase = 2;
    end
    if (bs != m_acc) begin
      m_diff++;
      if (m_diff == D) begin m_acc = bs; m_diff = 0; end
    end else begin
      m_diff = 0;
    end
    for (int i = SY - 1; i > 0; i--) begin dl_lock[i] = dl_lock[i-1]; dl_btn[i] = dl_btn[i-1]; end
    dl_lock[0] = lock;
    dl_btn[0]  = button_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("model.reset_out", reset_out, m_rst_out());
    check("model.ready", ready, (m_phase == 2));
    check("model.state", state, m_phase);
    check("model.lock_loss_count", lock_loss_count, m_llc);
  endtask

  task automatic wait_ready(input int budget, input string name);
    int i;
    for (i = 0; i < budget && !ready; i++) tick();
    check({name, ".ready_within_budget"}, ready, 1);
  endtask

  typedef struct {
    bit           rst, lk, btn, sw;
    int           ticks;
    logic [N-1:0] exp_ro;
    bit           exp_rdy;
    int           exp_st;
    int           exp_llc;
  } vec_t;

  vec_t vecs[14];
  int   btn_low = 0;

  initial begin
    // Power-up, then lock loss in RUN and relock.
    vecs[0]  = '{1, 1, 1, 0,  5, 3'b111, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 17, 3'b111, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 0,  1, 3'b110, 0, 1, 0};
    vecs[3]  = '{0, 1, 1, 0,  3, 3'b110, 0, 1, 0};
    vecs[4]  = '{0, 1, 1, 0,  1, 3'b100, 0, 1, 0};
    vecs[5]  = '{0, 1, 1, 0,  3, 3'b100, 0, 1, 0};
    vecs[6]  = '{0, 1, 1, 0,  1, 3'b000, 1, 2, 0};
    vecs[7]  = '{0, 1, 1, 0, 10, 3'b000, 1, 2, 0};
    vecs[8]  = '{0, 0, 1, 0,  2, 3'b000, 1, 2, 0};
    vecs[9]  = '{0, 0, 1, 0,  1, 3'b111, 0, 0, 1};
    vecs[10] = '{0, 1, 1, 0, 17, 3'b111, 0, 0, 1};
    vecs[11] = '{0, 1, 1, 0,  1, 3'b110, 0, 1, 1};
    vecs[12] = '{0, 1, 1, 0,  4, 3'b100, 0, 1, 1};
    vecs[13] = '{0, 1, 1, 0,  4, 3'b000, 1, 2, 1};

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst; lock = vecs[i].lk; button_n = vecs[i].btn; sw_req = vecs[i].sw;
      repeat (vecs[i].ticks) tick();
      check($sformatf("vec%0d.reset_out", i), reset_out, vecs[i].exp_ro);
      check($sformatf("vec%0d.ready", i), ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d.state", i), state, vecs[i].exp_st);
      check($sformatf("vec%0d.lock_loss_count", i), lock_loss_count, vecs[i].exp_llc);
    end

    // Short button bounce is ignored.
    button_n = 0; repeat (5) tick();
    button_n = 1; repeat (15) tick();
    check("bounce.state", state, 2);
    check("bounce.ready", ready, 1);

    // Long press: pressed after SY+D edges, abort on the following edge.
    button_n = 0; repeat (10) tick();
    check("press.before_abort.state", state, 2);
    tick();
    check("press.abort.state", state, 0);
    check("press.abort.reset_out", reset_out, 3'b111);
    check("press.abort.llc", lock_loss_count, 1);
    repeat (9) tick();
    button_n = 1; repeat (25) tick();
    check("press.hold.reset_out", reset_out, 3'b111);
    tick();
    check("press.release.reset_out", reset_out, 3'b110);
    check("press.release.state", state, 1);

    // sw_req in STAGE aborts without counting.
    sw_req = 1; tick(); sw_req = 0;
    check("sw_stage.reset_out", reset_out, 3'b111);
    check("sw_stage.state", state, 0);
    check("sw_stage.llc", lock_loss_count, 1);

    // sw_req with the hold counter at 3 restarts the full hold.
    repeat (12) tick();
    sw_req = 1; tick(); sw_req = 0;
    repeat (15) tick();
    check("sw_hold.still_held", reset_out, 3'b111);
    tick();
    check("sw_hold.release", reset_out, 3'b110);
    wait_ready(20, "sw_hold");

    // Saturation: 300 lock drops in RUN.
    for (int i = 0; i < 300; i++) begin
      lock = 0; tick();
      lock = 1; tick(); tick();
      wait_ready(40, "sat");
    end
    check("sat.llc", lock_loss_count, 255);

    // reset beats coincident sw_req and lock drop.
    reset = 1; sw_req = 1; lock = 0; tick();
    check("prio.llc", lock_loss_count, 0);
    check("prio.state", state, 0);
    check("prio.reset_out", reset_out, 3'b111);
    reset = 0; sw_req = 0; lock = 1;
    wait_ready(40, "prio");

    // Lock loss and sw_req together count once.
    lock = 0; tick(); tick();
    sw_req = 1; tick(); sw_req = 0; lock = 1;
    check("simul.llc", lock_loss_count, 1);
    check("simul.state", state, 0);
    repeat (3) tick();
    check("simul.llc_hold", lock_loss_count, 1);
    wait_ready(40, "simul");

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      lock = ($urandom_range(0, 63) != 0);
      if (btn_low > 0) begin
        btn_low--;
        button_n = 0;
      end else if ($urandom_range(0, 99) == 0) begin
        btn_low  = $urandom_range(1, 20);
        button_n = 0;
      end else begin
        button_n = 1;
      end
      sw_req = ($urandom_range(0, 127) == 0);
      reset  = ($urandom_range(0, 511) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
